// File: rtl/dram_req_fifo.sv
// dram_req_fifo: FWFT request queue feeding the DRAM command generator, with occupancy, peak watermark and a sticky pop-while-empty flag
module dram_req_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [DATA_W-1:0] in_wdata,
    input  logic              in_rw,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] write_data,
    output logic              r_w,
    output logic              fifo_empty,
    input  logic              pop,
    output logic [CNT_W-1:0]  count,
    output logic [CNT_W-1:0]  max_count,
    output logic              pop_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = ADDR_W + DATA_W + 1;

    logic [EW-1:0]    mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d, max_q, max_d;
    logic             err_q, err_d;
    logic             full, empty, push, retire;

    assign empty      = wptr_q == rptr_q;
    assign full       = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
    assign push       = in_valid && !full;
    assign retire     = pop && !empty;
    assign in_ready   = !full;
    assign fifo_empty = empty;
    assign count      = count_q;
    assign max_count  = max_q;
    assign pop_err    = err_q;
    assign {address, write_data, r_w} = empty ? '0 : mem_q[rptr_q[AW-1:0]];

    // Next-state for pointers, occupancy, watermark and error flag
    always_comb begin
        wptr_d  = push ? wptr_q + (AW+1)'(1) : wptr_q;
        rptr_d  = retire ? rptr_q + (AW+1)'(1) : rptr_q;
        count_d = (push && !retire) ? count_q + CNT_W'(1) :
                  (retire && !push) ? count_q - CNT_W'(1) : count_q;
        max_d   = (count_d > max_q) ? count_d : max_q;
        err_d   = err_q || (pop && empty);
    end

    // Control state; active-low synchronous reset drops every queued entry
    always_ff @(posedge clk) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            max_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            max_q   <= max_d;
            err_q   <= err_d;
        end
    end

    // Entry storage; not reset since pointers alone define validity
    always_ff @(posedge clk) begin
        if (push && reset) mem_q[wptr_q[AW-1:0]] <= {in_addr, in_wdata, in_rw};
    end
endmodule

// File: tb/tb_dram_req_fifo.sv
// tb_dram_req_fifo: randomized scoreboard bench for dram_req_fifo against a queue-based reference model
module tb_dram_req_fifo;
    localparam int DEPTH = 16;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic        rw;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_rw, pop;
    logic        in_ready, r_w, fifo_empty, pop_err;
    logic [31:0] in_addr, in_wdata, address, write_data;
    logic [4:0]  count, max_count;

    int   checks   = 0;
    int   failures = 0;
    ent_t q[$];
    int   mmax  = 0;
    bit   merr  = 1'b0;
    bit   armed = 1'b0;
    bit   last_acc = 1'b0;

    dram_req_fifo #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_wdata(in_wdata), .in_rw(in_rw),
        .address(address), .write_data(write_data), .r_w(r_w),
        .fifo_empty(fifo_empty), .pop(pop), .count(count),
        .max_count(max_count), .pop_err(pop_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    // Reference model: queue semantics applied at each rising edge
    always @(posedge clk) begin
        if (!reset) begin
            q.delete();
            mmax     = 0;
            merr     = 1'b0;
            armed    = 1'b1;
            last_acc = 1'b0;
        end else begin
            last_acc = in_valid && (q.size() < DEPTH);
            if (pop && q.size() == 0) merr = 1'b1;
            if (pop && q.size() > 0) void'(q.pop_front());
            if (last_acc) q.push_back('{a: in_addr, d: in_wdata, rw: in_rw});
            if (q.size() > mmax) mmax = q.size();
        end
    end

    // Monitor: compares the presented head and status with the model mid-cycle
    always @(negedge clk) begin
        if (armed) begin
            chk("count", 64'(count), 64'(q.size()));
            chk("fifo_empty", 64'(fifo_empty), 64'(q.size() == 0));
            chk("in_ready", 64'(in_ready), 64'(q.size() != DEPTH));
            chk("max_count", 64'(max_count), 64'(mmax));
            chk("pop_err", 64'(pop_err), 64'(merr));
            chk("address", 64'(address), q.size() ? 64'(q[0].a) : 64'd0);
            chk("write_data", 64'(write_data), q.size() ? 64'(q[0].d) : 64'd0);
            chk("r_w", 64'(r_w), q.size() ? 64'(q[0].rw) : 64'd0);
        end
    end

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d,
                         input logic rw, input logic p);
        in_valid = v;
        in_addr  = a;
        in_wdata = d;
        in_rw    = rw;
        pop      = p;
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() > 0; i++) drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        idle();
    endtask

    initial begin
        reset = 1'b0;
        in_valid = 1'b0; in_addr = '0; in_wdata = '0; in_rw = 1'b0; pop = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        idle();
        // Three reads, popped one at a time with idle gaps
        drive(1'b1, 32'h2000, 32'h0, 1'b0, 1'b0);
        drive(1'b1, 32'h2080, 32'h0, 1'b0, 1'b0);
        drive(1'b1, 32'h2100, 32'h0, 1'b0, 1'b0);
        repeat (3) begin
            idle();
            drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        end
        idle();
        // Fill to full, offer a 17th, pop once while still offering it
        for (int i = 0; i < 17; i++) drive(1'b1, 32'h3000 + 32'(i), $urandom, i[0], 1'b0);
        drive(1'b1, 32'h3010, 32'hABCD, 1'b1, 1'b1);
        drive(1'b1, 32'h3010, 32'hABCD, 1'b1, 1'b0);
        idle();
        drain();
        // Wrap-around: 40 entries, data = index, alternating direction, random pops
        begin
            int idx = 0;
            for (int c = 0; c < 1000 && (idx < 40 || q.size() > 0); c++) begin
                logic v;
                v = (idx < 40) && ($urandom_range(0, 3) != 0);
                drive(v, 32'h4000 + 32'(idx), 32'(idx), idx[0], ($urandom_range(0, 2) == 0));
                if (v && last_acc) idx++;
            end
        end
        idle();
        // Hold occupancy at 5 with simultaneous push and pop
        for (int i = 0; i < 5; i++) drive(1'b1, 32'h5000 + 32'(i), 32'(i), 1'b1, 1'b0);
        for (int i = 5; i < 15; i++) drive(1'b1, 32'h5000 + 32'(i), 32'(i), i[0], 1'b1);
        idle();
        drain();
        // Pop while empty, then pop while empty together with a push
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
        idle();
        drive(1'b1, 32'h6000, 32'h66, 1'b1, 1'b1);
        idle();
        drain();
        // Reset with 7 queued, push and pop asserted in the reset cycle
        for (int i = 0; i < 7; i++) drive(1'b1, 32'h7000 + 32'(i), $urandom, 1'b0, 1'b0);
        reset = 1'b0;
        drive(1'b1, 32'h7777, 32'h77, 1'b1, 1'b1);
        reset = 1'b1;
        idle();
        drive(1'b1, 32'h8000, 32'h88, 1'b1, 1'b0);
        idle();
        // Random traffic
        for (int c = 0; c < 400; c++)
            drive($urandom_range(0, 1), $urandom, $urandom, $urandom_range(0, 1), $urandom_range(0, 1));
        idle();
        drain();
        idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dram_req_fifo.md
# dram_req_fifo

Request queue sitting directly upstream of the DRAM command generator (`generate_instruction`). It buffers read/write requests from the host side and presents the oldest one in first-word-fall-through form on `address`/`write_data`/`r_w`, with `fifo_empty` low while a request is present. The entry is retired when the command generator pulses `pop` after issuing the matching RD/WR. It also provides occupancy and a peak-occupancy watermark for the performance benches, plus a sticky error flag for pops while empty.

## Interface
- `DEPTH`, 16: number of entries; power of two, ≥2.
- `ADDR_W`, 32: request address width.
- `DATA_W`, 32: write data width.
- `CNT_W`, $clog2(DEPTH)+1: width of the occupancy counters.

- `clk` input 1: clock; all state updates on the rising edge.
- `reset` input 1: synchronous, active-low.
- `in_valid` input 1: host request valid.
- `in_ready` output 1: queue can accept; equals `count != DEPTH`.
- `in_addr` input ADDR_W: host request address.
- `in_wdata` input DATA_W: host write data.
- `in_rw` input 1: 0 = read, 1 = write (same encoding as controller `r_w`).
- `address` output ADDR_W: head entry address to the controller.
- `write_data` output DATA_W: head entry write data.
- `r_w` output 1: head entry direction.
- `fifo_empty` output 1: high when no entry is held.
- `pop` input 1: controller retire strobe, one cycle per completed request.
- `count` output CNT_W: current occupancy.
- `max_count` output CNT_W: peak occupancy since reset.
- `pop_err` output 1: sticky; set by `pop` while empty.

## Operation
- Storage: a DEPTH-entry array of {addr, wdata, rw}.
- Pointers: write and read pointers, each log2(DEPTH)+1 bits. Index uses the low bits; the MSB is a wrap bit.
  - Empty: pointers equal.
  - Full: low bits equal and MSBs differ.
- Push: accepted when `in_valid && in_ready`. Writes the entry at the write pointer, then the write pointer increments.
- Retire: accepted when `pop && !fifo_empty`. The read pointer increments.
- `pop` while empty: ignored for pointers and count. Sets `pop_err`, which stays set until reset.
- Head outputs: combinational read of the array at the read pointer (FWFT). When `fifo_empty` = 1, `address`, `write_data` and `r_w` are forced to 0.
- Head outputs are stable for as long as the entry is at the head. The controller may sample them over many cycles (ACT/PRE/RD sequences) before it pops.
- `count`:
  - +1 on push only; −1 on retire only.
  - Unchanged when push and retire happen in the same cycle.
  - Never exceeds DEPTH and never underflows.
- `max_count`: updated to the next-cycle `count` whenever that value exceeds the current `max_count`.
- Full with `pop`: `in_ready` is 0 during that cycle, so no push. `in_ready` returns to 1 the following cycle. There is no full-bypass path.
- Empty with `in_valid` and `pop` in the same cycle: the push is accepted, the pop is ignored and flagged in `pop_err`, and the entry appears at the next cycle.

## Timing
- Reset (`reset` = 0 at a rising edge): both pointers 0, `count` = 0, `max_count` = 0, `pop_err` = 0, `fifo_empty` = 1, `in_ready` = 1, `address`/`write_data`/`r_w` = 0. Array contents are not cleared.
- Reset mid-operation discards all queued entries. Any `pop` or push in the reset cycle is ignored.
- Push-to-visible latency: 1 cycle. A push at edge N gives `fifo_empty` = 0 and the head outputs valid just after edge N.
- Retire-to-next-head: 0 extra cycles. After the edge that samples `pop`, the next entry is presented, or `fifo_empty` rises if none is left.
- `fifo_empty`, `in_ready` and `count` are registered-state derived and glitch-free within a cycle.
- Sustained throughput: one push and one retire per cycle.

## Test plan
- Reset, then push 3 reads (addr 0x2000, 0x2080, 0x2100):
  - `fifo_empty` falls 1 cycle after the first push and `address` = 0x2000.
  - After each `pop`, `address` steps to 0x2080, then 0x2100.
  - After the third `pop`, `fifo_empty` = 1 and `address` = 0; `count` reads 3→2→1→0.
- Fill 16 entries without popping:
  - `in_ready` = 0 when `count` = 16; a 17th `in_valid` is not accepted.
  - Pop once: `in_ready` = 1 the next cycle; push the 17th; head order is preserved.
- Wrap-around: push/pop 40 entries with data = index, `in_rw` alternating.
  - Every popped {`address`, `write_data`, `r_w`} matches in order.
  - `max_count` equals the peak occupancy reached.
- Simultaneous push and pop at `count` = 5 for 10 cycles:
  - `count` stays 5 and the data order is intact.
- `pop` while empty:
  - `pop_err` = 1 and stays 1; `count` stays 0.
  - A push in the same cycle is accepted (`count` = 1 next cycle).
- Assert `reset` = 0 with 7 entries queued:
  - Next cycle `count` = 0, `fifo_empty` = 1, `max_count` = 0, `pop_err` = 0, outputs 0.
  - A new push after reset is presented correctly.
